// File: rtl/prog_mod_counter_pkg.sv
// Shared types and constants for the programmable modulo counter.
package prog_mod_counter_pkg;

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/prog_mod_counter_if.sv
// Control/status bundle of prog_mod_counter; the counter takes the slave side.
interface prog_mod_counter_if #(
    parameter int unsigned W = 16
) ();

    logic         en;
    logic         clr;
    logic [W-1:0] mod_i;
    logic         mod_wr;
    logic         dir;
    logic         oneshot;
    logic         start;
    logic [W-1:0] cnt_o;
    logic         co;
    logic         busy;

    modport master (
        output en, clr, mod_i, mod_wr, dir, oneshot, start,
        input  cnt_o, co, busy
    );

    modport slave (
        input  en, clr, mod_i, mod_wr, dir, oneshot, start,
        output cnt_o, co, busy
    );

endinterface

// File: rtl/prog_mod_counter.sv
// Programmable modulo counter: shadowed modulus, up/down, free-run or one-shot, combinational co.
// Define PROG_MOD_COUNTER_WRAP_CNT_EN to add the wrap_cnt output (WC_W bits).
module prog_mod_counter
    import prog_mod_counter_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned DEF_MOD = 64
`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
    ,
    parameter int unsigned WC_W    = 8
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    prog_mod_counter_if.slave      bus
`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
    ,
    output logic [WC_W-1:0]        wrap_cnt
`endif
);

    localparam logic [W-1:0] DefMod = W'(DEF_MOD);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] mod_act_q, mod_act_d;
    logic [W-1:0] mod_sh_q, mod_sh_d;
    logic         pend_q, pend_d;
    state_e       state_q, state_d;

    logic         active;
    logic         terminal;
    logic         wrap;
    logic         apply_sh;
    logic [W-1:0] mod_next;
    logic [W-1:0] start_val;

    // A pending shadow lands on a wrap, a clear, or any edge while not counting.
    always_comb begin
        active    = (state_q == RUN) | ~bus.oneshot;
        terminal  = (bus.dir == DIR_DN) ? (cnt_q == '0) : (cnt_q == (mod_act_q - W'(1)));
        wrap      = bus.en & active & terminal;
        apply_sh  = pend_q & (bus.clr | wrap | ~active);
        mod_next  = apply_sh ? mod_sh_q : mod_act_q;
        start_val = (bus.dir == DIR_DN) ? (mod_next - W'(1)) : '0;
    end

    always_comb begin
        cnt_d     = cnt_q;
        mod_act_d = mod_next;
        mod_sh_d  = mod_sh_q;
        pend_d    = pend_q & ~apply_sh;

        // A write coinciding with an apply stays pending for the next one.
        if (bus.mod_wr && (bus.mod_i != '0)) begin
            mod_sh_d = bus.mod_i;
            pend_d   = 1'b1;
        end

        if (bus.clr) begin
            cnt_d = start_val;
        end else if (active && bus.en) begin
            if (wrap) begin
                cnt_d = start_val;
            end else if (bus.dir == DIR_DN) begin
                cnt_d = cnt_q - W'(1);
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (apply_sh) begin
            cnt_d = start_val;
        end
    end

    // Free-running is treated as RUN so that raising oneshot finishes the current pass.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.oneshot || bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.oneshot && wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.clr) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mod_act_q <= DefMod;
            mod_sh_q  <= DefMod;
            pend_q    <= 1'b0;
            state_q   <= IDLE;
        end else begin
            cnt_q     <= cnt_d;
            mod_act_q <= mod_act_d;
            mod_sh_q  <= mod_sh_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
        end
    end

    assign bus.cnt_o = cnt_q;
    assign bus.co    = wrap;
    assign bus.busy  = active;

`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
    logic [WC_W-1:0] wrap_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            wrap_cnt_q <= '0;
        end else if (wrap) begin
            wrap_cnt_q <= wrap_cnt_q + WC_W'(1);
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed self-checking bench for prog_mod_counter (W = 16, DEF_MOD = 64).
module tb_prog_mod_counter;

    logic clk;
    logic rst_n;

    prog_mod_counter_if #(.W(16)) bus ();

`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
    logic [7:0] wrap_cnt;
`endif

    prog_mod_counter #(
        .W       (16),
        .DEF_MOD (64)
`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
        ,
        .WC_W    (8)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
        ,
        .wrap_cnt (wrap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int dn_cnt[8]  = '{3, 2, 1, 0, 3, 2, 3, 0};
    bit dn_co[8]   = '{0, 0, 0, 1, 0, 0, 1, 0};
    int sh_cnt[13] = '{0, 1, 2, 0, 1, 2, 3, 0, 1, 2, 3, 4, 0};
    bit sh_co[13]  = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle, then advance one edge.
    task automatic step_chk(input string tag, input int c, input bit o, input bit b);
        @(negedge clk);
        check({tag, "_cnt"}, 32'(bus.cnt_o), 32'(c));
        check({tag, "_co"}, 32'(bus.co), 32'(o));
        check({tag, "_busy"}, 32'(bus.busy), 32'(b));
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.clr     = 1'b0;
        bus.mod_i   = '0;
        bus.mod_wr  = 1'b0;
        bus.dir     = 1'b0;
        bus.oneshot = 1'b1;
        bus.start   = 1'b0;
        repeat (2) tick();

        // Reset state
        @(negedge clk);
        check("rst_cnt", 32'(bus.cnt_o), 32'd0);
        check("rst_co", 32'(bus.co), 32'd0);
        check("rst_busy_os", 32'(bus.busy), 32'd0);
        bus.oneshot = 1'b0;
        #1;
        check("rst_busy_fr", 32'(bus.busy), 32'd1);
        tick();

        // Free-run up, default modulus 64
        rst_n  = 1'b1;
        bus.en = 1'b1;
        for (int i = 0; i < 130; i++) begin
            step_chk($sformatf("fr%0d", i), i % 64, (i % 64) == 63, 1'b1);
        end

        // Modulus write mid-count, then a zero write that must be ignored
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        for (int j = 0; j < 80; j++) begin
            bus.mod_wr = (j == 10) || (j == 70);
            bus.mod_i  = (j == 10) ? 16'd5 : 16'd0;
            step_chk($sformatf("mw%0d", j),
                     (j < 64) ? j : (j - 64) % 5,
                     (j == 63) || ((j >= 64) && ((j - 64) % 5 == 4)), 1'b1);
        end
        bus.mod_wr = 1'b0;

        // Down count M = 4, direction flip at cnt 2
        bus.en     = 1'b0;
        bus.mod_i  = 16'd4;
        bus.mod_wr = 1'b1;
        tick();
        bus.mod_wr = 1'b0;
        bus.dir    = 1'b1;
        bus.clr    = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.en  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) bus.dir = 1'b0;
            step_chk($sformatf("dn%0d", k), dn_cnt[k], dn_co[k], 1'b1);
        end

        // One-shot M = 3
        bus.en     = 1'b0;
        bus.mod_i  = 16'd3;
        bus.mod_wr = 1'b1;
        tick();
        bus.mod_wr  = 1'b0;
        bus.oneshot = 1'b1;
        bus.clr     = 1'b1;
        tick();
        bus.clr   = 1'b0;
        bus.en    = 1'b1;
        bus.start = 1'b1;
        step_chk("os_arm", 0, 1'b0, 1'b0);
        bus.start = 1'b0;
        step_chk("os_c0", 0, 1'b0, 1'b1);
        bus.start = 1'b1;
        step_chk("os_c1", 1, 1'b0, 1'b1);
        bus.start = 1'b0;
        step_chk("os_c2", 2, 1'b1, 1'b1);
        step_chk("os_done", 0, 1'b0, 1'b0);
        step_chk("os_hold", 0, 1'b0, 1'b0);

        // clr together with wrap and start
        bus.start = 1'b1;
        step_chk("sim_arm", 0, 1'b0, 1'b0);
        bus.start = 1'b0;
        step_chk("sim_c0", 0, 1'b0, 1'b1);
        step_chk("sim_c1", 1, 1'b0, 1'b1);
        bus.clr   = 1'b1;
        bus.start = 1'b1;
        step_chk("sim_wrap", 2, 1'b1, 1'b1);
        step_chk("clr_start", 0, 1'b0, 1'b0);
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        step_chk("clr_start_idle", 0, 1'b0, 1'b0);

        // Shadow writes: one before a wrap, one on the wrap cycle
        bus.oneshot = 1'b0;
        for (int k = 0; k < 13; k++) begin
            bus.mod_wr = (k == 0) || (k == 2);
            bus.mod_i  = (k == 0) ? 16'd4 : 16'd5;
            step_chk($sformatf("sh%0d", k), sh_cnt[k], sh_co[k], 1'b1);
        end
        bus.mod_wr = 1'b0;

        // M == 1
        bus.en     = 1'b0;
        bus.mod_i  = 16'd1;
        bus.mod_wr = 1'b1;
        tick();
        bus.mod_wr = 1'b0;
        bus.clr    = 1'b1;
        tick();
        bus.clr = 1'b0;
        bus.en  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step_chk($sformatf("m1_%0d", k), 0, 1'b1, 1'b1);
        end
        bus.en = 1'b0;
        step_chk("m1_en0", 0, 1'b0, 1'b1);

        // Reset mid-operation drops a pending shadow
        bus.mod_i  = 16'd7;
        bus.mod_wr = 1'b1;
        tick();
        bus.mod_wr = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n   = 1'b1;
        bus.dir = 1'b1;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        step_chk("rst_drop", 63, 1'b0, 1'b1);
        bus.en = 1'b1;
        step_chk("rst_dn0", 63, 1'b0, 1'b1);
        step_chk("rst_dn1", 62, 1'b0, 1'b1);

`ifdef PROG_MOD_COUNTER_WRAP_CNT_EN
        bus.en  = 1'b0;
        bus.dir = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n      = 1'b1;
        bus.mod_i  = 16'd2;
        bus.mod_wr = 1'b1;
        tick();
        bus.mod_wr = 1'b0;
        bus.clr    = 1'b1;
        tick();
        bus.clr = 1'b0;
        @(negedge clk);
        check("wc_init", 32'(wrap_cnt), 32'd0);
        tick();
        bus.en = 1'b1;
        repeat (600) tick();
        bus.en = 1'b0;
        @(negedge clk);
        check("wc_600", 32'(wrap_cnt), 32'd44);
        tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        @(negedge clk);
        check("wc_clr", 32'(wrap_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
